instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Multicycle fetch stage that owns the PC and the instruction register (IR), and supplies the 32-bit `instruction` word to the processor datapath and control unit. Runs a MOV/MOC handshake against the byte-addressed, big-endian 512x8 RAM: one word is assembled from Address..Address+3. Applies branch and jump redirects from the control unit. Feeds the datapath's `instruction` input directly.

Parameters:
ADDR_WIDTH, 9, width of the PC and the memory byte address.
RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0.
TIMEOUT_CYCLES, 16, WAIT-state cycle limit, used only with the optional feature.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
fetch_req  in  1  control unit requests the next instruction; level-sensitive, sampled in IDLE
redirect  in  1  one-cycle pulse: load a new PC
redirect_jump  in  1  with redirect: 1 = jump, 0 = branch
branch_offset  in  16  signed word offset (IR[15:0])
jump_target  in  26  word target (IR[25:0])
MOC  in  1  memory operation complete
DataIn  in  32  memory read data
MOV  out  1  memory operation valid
MemRead  out  1  read strobe
Address  out  ADDR_WIDTH  byte address to memory
instruction  out  32  IR contents
ir_valid  out  1  one-cycle pulse: IR updated
pc  out  ADDR_WIDTH  current PC
busy  out  1  FSM not in IDLE
fetch_error  out  1  sticky timeout flag; tied 0 when the feature is off

Behaviour:
- Reset (async, reset low), all outputs registered:
  - pc=RESET_PC, instruction=0, ir_valid=0, MOV=0, MemRead=0, Address=0, busy=0, fetch_error=0.
  - Pending-redirect register cleared; FSM=IDLE.
  - Reset asserted mid-fetch aborts immediately. MOV drops asynchronously.
- States: IDLE, REQ, WAIT, DONE.
  - IDLE -> REQ when fetch_req=1. At that edge, Address<=pc.
  - REQ: MOV=1, MemRead=1. Go to WAIT next cycle.
  - WAIT: MOV and MemRead held high. On the first edge where MOC=1: capture DataIn, drop MOV/MemRead, go to DONE. Otherwise stay in WAIT.
  - DONE, no pending redirect: instruction<=captured word, ir_valid=1 for this cycle only, pc<=pc+4. Go to IDLE.
  - DONE, pending redirect: discard the captured word (ir_valid=0, instruction unchanged), pc<=pending target. Go to IDLE.
- Latency: fetch_req seen in IDLE to ir_valid = 3 + (WAIT cycles) edges. Minimum 4, when MOC is high on the first WAIT edge.
- MOC rules:
  - Sampled synchronously.
  - The memory must hold MOC until MOV falls.
  - MOC=1 in IDLE, REQ or DONE is ignored.
- Redirect target arithmetic, modulo 2^ADDR_WIDTH:
  - Branch: pc_base + 4 + (sign_extend(branch_offset) << 2).
  - Jump: low ADDR_WIDTH bits of {jump_target, 2'b00}.
  - pc_base is the address of the instruction currently in IR, i.e. pc-4 after a DONE.
- Redirect timing:
  - redirect in IDLE: pc is updated at that edge.
  - redirect in REQ or WAIT: the target is stored as pending and applied in DONE.
  - Two redirects in one fetch: the last one wins.
  - redirect and fetch_req together in IDLE: redirect has priority. pc is loaded and the FSM stays IDLE for that cycle; the fetch starts on the next edge if fetch_req is still high.
- Wrap-around: pc+4 from 508 (0x1FC) gives 0. No overflow flag.
- pc low 2 bits are always 0. Computed targets are word-aligned by construction.
- fetch_req in non-IDLE states is ignored; requests are not queued.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A WAIT-cycle counter runs from entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without MOC: fetch_error<=1 (sticky until reset), MOV/MemRead drop, IR and pc are left unchanged, FSM goes to IDLE.
  - A pending redirect is still applied to pc.
- Undefined: no counter. WAIT lasts indefinitely. fetch_error is constant 0.

Test Plan:
1. Reset low then high, RAM[0..3]=24 01 00 2C, fetch_req=1, MOC returned on the first WAIT edge -> at edge 4: instruction=0x2401002C, ir_valid one cycle, pc=4.
2. IR at pc=0x10, redirect pulse in IDLE, redirect_jump=0, branch_offset=0xFFFD -> pc=0x10+4-12=0x08. The next fetch puts Address=0x08.
3. Fetch in WAIT with MOC withheld 5 cycles, redirect_jump=1, jump_target=0x000004 pulsed during WAIT -> when MOC arrives: ir_valid stays 0, instruction unchanged, pc=0x10.
4. pc=0x1FC, fetch completes -> pc=0x000. The next Address=0x000.
5. reset dropped while in WAIT with MOV=1 -> MOV=0 immediately, pc=RESET_PC, busy=0, no ir_valid.
6. With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, MOC never asserted -> after 16 WAIT cycles: fetch_error=1, MOV=0, FSM in IDLE, pc unchanged.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Multicycle fetch stage: owns PC and IR, runs the MOV/MOC read handshake, applies branch/jump redirects.
// Optional WAIT-state timeout with sticky fetch_error is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH     = 9,
    parameter int RESET_PC       = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic                  redirect,
    input  logic                  redirect_jump,
    input  logic [15:0]           branch_offset,
    input  logic [25:0]           jump_target,
    input  logic                  MOC,
    input  logic [31:0]           DataIn,
    output logic                  MOV,
    output logic                  MemRead,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [31:0]           instruction,
    output logic                  ir_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  fetch_error
);

    // state  | meaning
    // S_IDLE | waiting for fetch_req; redirects load pc directly
    // S_REQ  | MOV/MemRead raised, Address valid
    // S_WAIT | holding MOV until MOC is sampled high
    // S_DONE | commit captured word, or apply the pending redirect instead
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

    state_t                  state;
    logic [31:0]             data_buf;
    logic                    pend_valid;
    logic [ADDR_WIDTH-1:0]   pend_target;
    logic [ADDR_WIDTH-1:0]   redirect_target;
    logic [31:0]             br_sum;
    logic [31:0]             jmp_addr;
    logic                    unused_bits;

    // pc already points one word past the IR instruction, so pc_base + 4 == pc.
    always_comb begin
        br_sum   = {{(32-ADDR_WIDTH){1'b0}}, pc} + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        jmp_addr = {4'b0000, jump_target, 2'b00};
        redirect_target = redirect_jump ? jmp_addr[ADDR_WIDTH-1:0] : br_sum[ADDR_WIDTH-1:0];
    end

    assign unused_bits = ^{br_sum[31:ADDR_WIDTH], jmp_addr[31:ADDR_WIDTH]};

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    assign fetch_error = err_q;
`else
    // No timeout hardware in this build; the comparison is a constant 0.
    assign fetch_error = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= PC_INIT;
            instruction <= '0;
            ir_valid    <= 1'b0;
            MOV         <= 1'b0;
            MemRead     <= 1'b0;
            Address     <= '0;
            busy        <= 1'b0;
            data_buf    <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            ir_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (redirect) begin
                        pc <= redirect_target;
                    end else if (fetch_req) begin
                        state   <= S_REQ;
                        Address <= pc;
                        MOV     <= 1'b1;
                        MemRead <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (redirect) begin
                        pend_valid  <= 1'b1;
                        pend_target <= redirect_target;
                    end
                    state <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                end
                S_WAIT: begin
                    if (redirect) begin
                        pend_valid  <= 1'b1;
                        pend_target <= redirect_target;
                    end
                    if (MOC) begin
                        data_buf <= DataIn;
                        MOV      <= 1'b0;
                        MemRead  <= 1'b0;
                        state    <= S_DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_cnt == '0) begin
                        err_q      <= 1'b1;
                        MOV        <= 1'b0;
                        MemRead    <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                        pend_valid <= 1'b0;
                        if (redirect)
                            pc <= redirect_target;
                        else if (pend_valid)
                            pc <= pend_target;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    pend_valid <= 1'b0;
                    if (redirect) begin
                        pc <= redirect_target;
                    end else if (pend_valid) begin
                        pc <= pend_target;
                    end else begin
                        instruction <= data_buf;
                        ir_valid    <= 1'b1;
                        pc          <= pc + ADDR_WIDTH'(4);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a byte-wide big-endian RAM responder.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        redirect;
    logic        redirect_jump;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic        MOC;
    logic [31:0] DataIn;
    logic        MOV;
    logic        MemRead;
    logic [8:0]  Address;
    logic [31:0] instruction;
    logic        ir_valid;
    logic [8:0]  pc;
    logic        busy;
    logic        fetch_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:511];
    int  moc_delay = 0;
    bit  mem_en = 1'b1;
    int  mov_cnt = 0;

    instruction_fetch_unit dut (
        .clock(clock), .reset(reset), .fetch_req(fetch_req), .redirect(redirect),
        .redirect_jump(redirect_jump), .branch_offset(branch_offset), .jump_target(jump_target),
        .MOC(MOC), .DataIn(DataIn), .MOV(MOV), .MemRead(MemRead), .Address(Address),
        .instruction(instruction), .ir_valid(ir_valid), .pc(pc), .busy(busy),
        .fetch_error(fetch_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [8:0] a);
        logic [8:0] a1, a2, a3;
        a1 = a + 9'd1;
        a2 = a + 9'd2;
        a3 = a + 9'd3;
        return {mem[a], mem[a1], mem[a2], mem[a3]};
    endfunction

    // MOC rises after (2 + moc_delay) low-phase samples of MOV, i.e. moc_delay WAIT edges without MOC.
    initial begin
        MOC = 1'b0;
        DataIn = '0;
        forever begin
            @(negedge clock);
            if (MOV && mem_en) begin
                mov_cnt++;
                if (mov_cnt >= 2 + moc_delay) begin
                    MOC = 1'b1;
                    DataIn = word_at(Address);
                end
            end else begin
                mov_cnt = 0;
                MOC = 1'b0;
            end
        end
    end

    task automatic do_fetch(input int delay, input int rd_edge, input bit rd_jump,
                            input logic [15:0] rd_off, input logic [25:0] rd_tgt,
                            output int edges, output bit saw_valid, output logic [8:0] addr1);
        moc_delay = delay;
        edges = 0;
        saw_valid = 1'b0;
        addr1 = '0;
        @(negedge clock);
        fetch_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            edges++;
            if (edges == 1) begin
                fetch_req = 1'b0;
                addr1 = Address;
            end
            redirect = 1'b0;
            if (edges == rd_edge) begin
                redirect = 1'b1;
                redirect_jump = rd_jump;
                branch_offset = rd_off;
                jump_target = rd_tgt;
            end
            if (ir_valid) saw_valid = 1'b1;
            if (!busy && edges > 1) break;
        end
        chk("fetch_bound", {31'd0, busy}, 32'd0);
    endtask

    task automatic redirect_idle(input bit jmp, input logic [15:0] off, input logic [25:0] tgt);
        @(negedge clock);
        redirect = 1'b1;
        redirect_jump = jmp;
        branch_offset = off;
        jump_target = tgt;
        @(posedge clock);
        #1;
        redirect = 1'b0;
    endtask

    localparam int STALL_EDGES =
`ifdef FETCH_TIMEOUT_EN
        4;
`else
        20;
`endif

    int          e;
    bit          v;
    logic [8:0]  a;
    logic [31:0] ir_prev;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 5);
        mem[0] = 8'h24; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h2C;
        reset = 1'b0;
        fetch_req = 1'b0;
        redirect = 1'b0;
        redirect_jump = 1'b0;
        branch_offset = '0;
        jump_target = '0;
        repeat (2) @(negedge clock);
        chk("rst_pc", {23'd0, pc}, 32'd0);
        chk("rst_ir", instruction, 32'd0);
        chk("rst_flags", {26'd0, ir_valid, MOV, MemRead, busy, fetch_error, 1'b0}, 32'd0);
        chk("rst_addr", {23'd0, Address}, 32'd0);
        reset = 1'b1;

        // first fetch, MOC on the first WAIT edge
        do_fetch(0, 0, 1'b0, '0, '0, e, v, a);
        chk("t1_latency", e, 4);
        chk("t1_valid", {31'd0, v}, 32'd1);
        chk("t1_ir", instruction, 32'h2401002C);
        chk("t1_pc", {23'd0, pc}, 32'd4);
        @(posedge clock); #1;
        chk("t1_valid_pulse", {31'd0, ir_valid}, 32'd0);

        // walk to IR = instruction at 0x10, pc = 0x14
        for (int k = 0; k < 4; k++) do_fetch(0, 0, 1'b0, '0, '0, e, v, a);
        chk("t2_pre_pc", {23'd0, pc}, 32'h14);
        chk("t2_pre_ir", instruction, word_at(9'h10));
        redirect_idle(1'b0, 16'hFFFD, '0);
        chk("t2_branch_pc", {23'd0, pc}, 32'h08);
        do_fetch(0, 0, 1'b0, '0, '0, e, v, a);
        chk("t2_addr", {23'd0, a}, 32'h08);
        chk("t2_ir", instruction, word_at(9'h08));
        chk("t2_pc", {23'd0, pc}, 32'h0C);

        // jump pulsed during WAIT, MOC withheld 5 WAIT edges
        ir_prev = instruction;
        do_fetch(5, 2, 1'b1, '0, 26'h000004, e, v, a);
        chk("t3_latency", e, 9);
        chk("t3_valid", {31'd0, v}, 32'd0);
        chk("t3_ir", instruction, ir_prev);
        chk("t3_pc", {23'd0, pc}, 32'h10);

        // branch pulsed during REQ becomes pending: 0x10 + 3*4
        do_fetch(2, 1, 1'b0, 16'h0003, '0, e, v, a);
        chk("t3b_latency", e, 6);
        chk("t3b_valid", {31'd0, v}, 32'd0);
        chk("t3b_pc", {23'd0, pc}, 32'h1C);
        do_fetch(1, 0, 1'b0, '0, '0, e, v, a);
        chk("t3b_addr", {23'd0, a}, 32'h1C);
        chk("t3b_latency2", e, 5);
        chk("t3b_ir", instruction, word_at(9'h1C));

        // wrap-around from 0x1FC
        redirect_idle(1'b1, '0, 26'h00007F);
        chk("t4_jump_pc", {23'd0, pc}, 32'h1FC);
        do_fetch(0, 0, 1'b0, '0, '0, e, v, a);
        chk("t4_addr", {23'd0, a}, 32'h1FC);
        chk("t4_ir", instruction, word_at(9'h1FC));
        chk("t4_pc_wrap", {23'd0, pc}, 32'h0);
        do_fetch(0, 0, 1'b0, '0, '0, e, v, a);
        chk("t4_next_addr", {23'd0, a}, 32'h0);
        chk("t4_next_pc", {23'd0, pc}, 32'h4);

        // redirect and fetch_req together: redirect wins, fetch starts on the next edge
        @(negedge clock);
        fetch_req = 1'b1;
        redirect = 1'b1;
        redirect_jump = 1'b1;
        jump_target = 26'h000010;
        @(posedge clock); #1;
        redirect = 1'b0;
        chk("prio_pc", {23'd0, pc}, 32'h40);
        chk("prio_idle", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        fetch_req = 1'b0;
        chk("prio_busy", {31'd0, busy}, 32'd1);
        chk("prio_addr", {23'd0, Address}, 32'h40);
        for (int i = 0; i < 20 && busy; i++) begin @(posedge clock); #1; end
        chk("prio_pc_after", {23'd0, pc}, 32'h44);
        chk("prio_ir", instruction, word_at(9'h40));

`ifdef FETCH_TIMEOUT_EN
        // MOC never arrives: timeout after 16 WAIT cycles
        mem_en = 1'b0;
        ir_prev = instruction;
        do_fetch(0, 0, 1'b0, '0, '0, e, v, a);
        chk("t6_edges", e, 18);
        chk("t6_error", {31'd0, fetch_error}, 32'd1);
        chk("t6_mov", {31'd0, MOV}, 32'd0);
        chk("t6_valid", {31'd0, v}, 32'd0);
        chk("t6_pc", {23'd0, pc}, 32'h44);
        chk("t6_ir", instruction, ir_prev);
`endif

        // stall in WAIT, then async reset mid-cycle
        mem_en = 1'b0;
        @(negedge clock);
        fetch_req = 1'b1;
        @(posedge clock); #1;
        fetch_req = 1'b0;
        repeat (STALL_EDGES - 1) @(posedge clock);
        #1;
        chk("t5_mov_held", {30'd0, MOV, busy}, 32'd3);
        chk("t5_no_error", {31'd0, fetch_error},
`ifdef FETCH_TIMEOUT_EN
            32'd1);
`else
            32'd0);
`endif
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        chk("t5_rst_mov", {30'd0, MOV, MemRead}, 32'd0);
        chk("t5_rst_pc", {23'd0, pc}, 32'd0);
        chk("t5_rst_busy", {30'd0, busy, ir_valid}, 32'd0);
        chk("t5_rst_err", {31'd0, fetch_error}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        mem_en = 1'b1;
        do_fetch(0, 0, 1'b0, '0, '0, e, v, a);
        chk("t5_refetch_ir", instruction, 32'h2401002C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
